// File: rtl/redmule_qw_unpacker_pkg.sv
// Shared types and helpers for the RedMulE quantized-weight unpacker.
// Holds the FSM state encoding, weight byte width and slices-per-beat arithmetic.
package redmule_qw_unpacker_pkg;

   typedef enum logic [1:0] {
      QW_IDLE      = 2'd0,
      QW_FETCH     = 2'd1,
      QW_EMIT      = 2'd2,
      QW_META_WAIT = 2'd3
   } qw_state_e;

   typedef enum logic [1:0] {
      FP32    = 2'd0,
      FP16    = 2'd1,
      FP16ALT = 2'd2,
      FP8     = 2'd3
   } fp_format_e;

   localparam int unsigned QW_BITS = 8;

   function automatic int unsigned fp_width(input fp_format_e fmt);
      case (fmt)
         FP32:    return 32;
         FP16:    return 16;
         FP16ALT: return 16;
         FP8:     return 8;
         default: return 16;
      endcase
   endfunction

   // A packed beat yields twice as many vectors when each byte carries two nibbles.
   function automatic int unsigned qw_num_slices(input int unsigned dw, input int unsigned h,
                                                 input logic int4);
      return int4 ? dw / (4 * h) : dw / (QW_BITS * h);
   endfunction

endpackage

// File: rtl/redmule_qw_slicer.sv
// Selects one H-lane weight vector out of a held packed beat (byte or nibble granularity).
// Purely combinational; nibbles are zero-extended to a full weight byte.
module redmule_qw_slicer
   import redmule_qw_unpacker_pkg::*;
#(
   parameter int unsigned DW = 288,
   parameter int unsigned H  = 4,
   parameter int unsigned SW = 5
) (
   input  logic [DW-1:0]         i_beat,
   input  logic [SW-1:0]         i_slice,
   input  logic                  i_int4,
   output logic [H*QW_BITS-1:0]  o_qw
);

   always_comb begin
      o_qw = '0;
      for (int l = 0; l < H; l++) begin
         if (i_int4)
            o_qw[l*QW_BITS +: QW_BITS] = {4'b0000, i_beat[(int'(i_slice)*H + l)*4 +: 4]};
         else
            o_qw[l*QW_BITS +: QW_BITS] = i_beat[(int'(i_slice)*H + l)*QW_BITS +: QW_BITS];
      end
   end

endmodule

// File: rtl/redmule_qw_unpacker.sv
// Serializes packed weight beats into H-lane vectors tagged with per-group scale/zero metadata.
// Optional packed 4-bit weights are compiled in with REDMULE_QW_INT4_EN.
module redmule_qw_unpacker
   import redmule_qw_unpacker_pkg::*;
#(
   parameter int unsigned DW         = 288,
   parameter fp_format_e  FpFormat   = FP16,
   parameter int unsigned Height     = 4,
   parameter int unsigned MaxGroupW  = 16,
   localparam int unsigned BITW      = fp_width(FpFormat)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        clear_i,
   input  logic [MaxGroupW-1:0]        group_size_i,
   input  logic                        meta_valid_i,
   output logic                        meta_ready_o,
   input  logic [Height*BITW-1:0]      meta_scales_i,
   input  logic [Height*QW_BITS-1:0]   meta_zeros_i,
   input  logic                        qw_valid_i,
   output logic                        qw_ready_o,
   input  logic [DW-1:0]               qw_data_i,
   input  logic                        int4_mode_i,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [Height*BITW-1:0]      scales_o,
   output logic [Height*QW_BITS-1:0]   zeros_o,
   output logic [Height*QW_BITS-1:0]   qw_o,
   output logic                        group_last_o
);

   localparam int unsigned NS_MAX = qw_num_slices(DW, Height, 1'b1);
   localparam int unsigned SW     = (NS_MAX > 1) ? $clog2(NS_MAX) : 1;

   qw_state_e                  r_state;
   logic                       r_meta_rdy;
   logic                       r_qw_rdy;
   logic [Height*BITW-1:0]     r_scales;
   logic [Height*QW_BITS-1:0]  r_zeros;
   logic [MaxGroupW-1:0]       r_gsize;
   logic [MaxGroupW-1:0]       r_grp_cnt;
   logic [SW-1:0]              r_slice_cnt;
   logic [DW-1:0]              r_beat;
   logic                       r_out_vld;
   logic [Height*BITW-1:0]     r_scales_o;
   logic [Height*QW_BITS-1:0]  r_zeros_o;
   logic [Height*QW_BITS-1:0]  r_qw_o;
   logic                       r_glast_o;

   logic                       w_int4;
   logic                       w_meta_hs;
   logic                       w_qw_hs;
   logic                       w_load;
   logic                       w_slice_last;
   logic                       w_grp_last;
   logic [SW-1:0]              w_ns_m1;
   logic [Height*QW_BITS-1:0]  w_slice_qw;

`ifdef REDMULE_QW_INT4_EN
   logic                       r_int4;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i)
         r_int4 <= 1'b0;
      else if (r_state == QW_IDLE && w_meta_hs)
         r_int4 <= int4_mode_i;
   end

   assign w_int4 = r_int4;
`else
   logic w_unused_int4;

   assign w_unused_int4 = int4_mode_i;
   assign w_int4        = 1'b0;
`endif

   assign w_meta_hs    = meta_valid_i & r_meta_rdy;
   assign w_qw_hs      = qw_valid_i & r_qw_rdy;
   assign w_load       = (r_state == QW_EMIT) & (~r_out_vld | out_ready_i);
   assign w_ns_m1      = SW'(qw_num_slices(DW, Height, w_int4) - 1);
   assign w_slice_last = (r_slice_cnt == w_ns_m1);
   assign w_grp_last   = (r_grp_cnt == r_gsize - MaxGroupW'(1));

   redmule_qw_slicer #(
      .DW (DW),
      .H  (Height),
      .SW (SW)
   ) u_slicer (
      .i_beat  (r_beat),
      .i_slice (r_slice_cnt),
      .i_int4  (w_int4),
      .o_qw    (w_slice_qw)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_state     <= QW_IDLE;
         r_meta_rdy  <= 1'b0;
         r_qw_rdy    <= 1'b0;
         r_scales    <= '0;
         r_zeros     <= '0;
         r_gsize     <= '0;
         r_grp_cnt   <= '0;
         r_slice_cnt <= '0;
         r_beat      <= '0;
         r_out_vld   <= 1'b0;
         r_scales_o  <= '0;
         r_zeros_o   <= '0;
         r_qw_o      <= '0;
         r_glast_o   <= 1'b0;
      end else begin
         if (r_out_vld && out_ready_i)
            r_out_vld <= 1'b0;

         case (r_state)
            QW_IDLE: begin
               r_meta_rdy <= 1'b1;
               if (w_meta_hs) begin
                  r_scales   <= meta_scales_i;
                  r_zeros    <= meta_zeros_i;
                  r_gsize    <= (group_size_i == '0) ? MaxGroupW'(1) : group_size_i;
                  r_grp_cnt  <= '0;
                  r_meta_rdy <= 1'b0;
                  r_qw_rdy   <= 1'b1;
                  r_state    <= QW_FETCH;
               end
            end

            QW_FETCH: begin
               if (w_qw_hs) begin
                  r_beat      <= qw_data_i;
                  r_slice_cnt <= '0;
                  r_qw_rdy    <= 1'b0;
                  r_state     <= QW_EMIT;
               end
            end

            QW_EMIT: begin
               if (w_load) begin
                  // Metadata is snapshotted with the vector so later reloads cannot disturb it.
                  r_out_vld   <= 1'b1;
                  r_qw_o      <= w_slice_qw;
                  r_scales_o  <= r_scales;
                  r_zeros_o   <= r_zeros;
                  r_glast_o   <= w_grp_last;
                  r_slice_cnt <= r_slice_cnt + SW'(1);
                  r_grp_cnt   <= w_grp_last ? '0 : r_grp_cnt + MaxGroupW'(1);
                  if (w_slice_last && w_grp_last) begin
                     r_meta_rdy <= 1'b1;
                     r_state    <= QW_IDLE;
                  end else if (w_slice_last) begin
                     r_qw_rdy   <= 1'b1;
                     r_state    <= QW_FETCH;
                  end else if (w_grp_last) begin
                     r_meta_rdy <= 1'b1;
                     r_state    <= QW_META_WAIT;
                  end
               end
            end

            QW_META_WAIT: begin
               if (w_meta_hs) begin
                  r_scales   <= meta_scales_i;
                  r_zeros    <= meta_zeros_i;
                  r_meta_rdy <= 1'b0;
                  r_state    <= QW_EMIT;
               end
            end

            default: r_state <= QW_IDLE;
         endcase
      end
   end

   assign meta_ready_o = r_meta_rdy;
   assign qw_ready_o   = r_qw_rdy;
   assign out_valid_o  = r_out_vld;
   assign scales_o     = r_scales_o;
   assign zeros_o      = r_zeros_o;
   assign qw_o         = r_qw_o;
   assign group_last_o = r_glast_o;

endmodule

// File: tb/tb_redmule_qw_unpacker.sv
// Directed bench for redmule_qw_unpacker with H=4, DW=288 (nine 4-byte slices per beat).
// Vector tables hold hand-computed weights/scales; corner cases are driven as explicit sequences.
module tb_redmule_qw_unpacker;
   import redmule_qw_unpacker_pkg::*;

   localparam int unsigned H    = 4;
   localparam int unsigned DW   = 288;
   localparam int unsigned BITW = 16;
   localparam int unsigned GW   = 16;

   logic              clk = 1'b0;
   logic              rst_i, clear_i;
   logic [GW-1:0]     group_size_i;
   logic              meta_valid_i, meta_ready_o;
   logic [H*BITW-1:0] meta_scales_i;
   logic [H*8-1:0]    meta_zeros_i;
   logic              qw_valid_i, qw_ready_o;
   logic [DW-1:0]     qw_data_i;
   logic              int4_mode_i;
   logic              out_valid_o, out_ready_i;
   logic [H*BITW-1:0] scales_o;
   logic [H*8-1:0]    zeros_o;
   logic [H*8-1:0]    qw_o;
   logic              group_last_o;

   always #5 clk = ~clk;

   redmule_qw_unpacker #(
      .DW        (DW),
      .FpFormat  (FP16),
      .Height    (H),
      .MaxGroupW (GW)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .clear_i       (clear_i),
      .group_size_i  (group_size_i),
      .meta_valid_i  (meta_valid_i),
      .meta_ready_o  (meta_ready_o),
      .meta_scales_i (meta_scales_i),
      .meta_zeros_i  (meta_zeros_i),
      .qw_valid_i    (qw_valid_i),
      .qw_ready_o    (qw_ready_o),
      .qw_data_i     (qw_data_i),
      .int4_mode_i   (int4_mode_i),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready_i),
      .scales_o      (scales_o),
      .zeros_o       (zeros_o),
      .qw_o          (qw_o),
      .group_last_o  (group_last_o)
   );

   typedef struct {
      logic [31:0] qw;
      logic [15:0] scale;
      logic [7:0]  zero;
      logic        glast;
   } vec_t;

   vec_t          tab4[9];
   vec_t          exp_v[18];
   logic [15:0]   meta_sc[16];
   logic [7:0]    meta_zr[16];
   logic [DW-1:0] beat;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] got_qw[$];
   logic [63:0] got_sc[$];
   logic [31:0] got_zr[$];
   logic        got_gl[$];
   int          metas_used;
   int          lat;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear_i      = 1'b1;
      meta_valid_i = 1'b0;
      qw_valid_i   = 1'b0;
      out_ready_i  = 1'b1;
      step();
      clear_i      = 1'b0;
   endtask

   // Drives metadata and one beat as the DUT asks for them and collects accepted vectors.
   task automatic run(input int gsz, input int nmeta, input int nvec,
                      input logic [3:0] rdy_pat, input logic int4);
      int cyc, mi, qi, meta_cyc, vld_cyc;
      got_qw.delete(); got_sc.delete(); got_zr.delete(); got_gl.delete();
      cyc = 0; mi = 0; qi = 0; meta_cyc = -1; vld_cyc = -1;
      group_size_i = GW'(gsz);
      int4_mode_i  = int4;
      qw_data_i    = beat;
      while (got_qw.size() < nvec && cyc < 400) begin
         meta_valid_i  = (mi < nmeta);
         meta_scales_i = {H{meta_sc[mi]}};
         meta_zeros_i  = {H{meta_zr[mi]}};
         qw_valid_i    = (qi < 1);
         out_ready_i   = rdy_pat[2'(cyc % 4)];
         @(negedge clk);
         if (meta_valid_i && meta_ready_o) begin
            if (mi == 0) meta_cyc = cyc;
            mi++;
         end
         if (qw_valid_i && qw_ready_o) qi++;
         if (out_valid_o && vld_cyc < 0) vld_cyc = cyc;
         if (out_valid_o && out_ready_i) begin
            got_qw.push_back(qw_o);
            got_sc.push_back(scales_o);
            got_zr.push_back(zeros_o);
            got_gl.push_back(group_last_o);
         end
         step();
         cyc++;
      end
      chk("vector_count", 64'(got_qw.size()), 64'(nvec));
      meta_valid_i = 1'b0;
      qw_valid_i   = 1'b0;
      out_ready_i  = 1'b1;
      metas_used   = mi;
      // Edges from the metadata handshake edge to the edge that raises out_valid_o.
      lat          = vld_cyc - meta_cyc - 1;
   endtask

   task automatic check_vecs(input string tag, input int nvec);
      for (int v = 0; v < nvec && v < got_qw.size(); v++) begin
         chk({tag, "_qw"},    64'(got_qw[v]), 64'(exp_v[v].qw));
         chk({tag, "_scale"}, got_sc[v],      {H{exp_v[v].scale}});
         chk({tag, "_zero"},  64'(got_zr[v]), 64'({H{exp_v[v].zero}}));
         chk({tag, "_glast"}, 64'(got_gl[v]), 64'(exp_v[v].glast));
      end
   endtask

   initial begin
      // Beat of bytes 0..35; group_size=4 with three metadata records.
      tab4[0] = '{32'h03020100, 16'h3800, 8'h11, 1'b0};
      tab4[1] = '{32'h07060504, 16'h3800, 8'h11, 1'b0};
      tab4[2] = '{32'h0B0A0908, 16'h3800, 8'h11, 1'b0};
      tab4[3] = '{32'h0F0E0D0C, 16'h3800, 8'h11, 1'b1};
      tab4[4] = '{32'h13121110, 16'h3C00, 8'h22, 1'b0};
      tab4[5] = '{32'h17161514, 16'h3C00, 8'h22, 1'b0};
      tab4[6] = '{32'h1B1A1918, 16'h3C00, 8'h22, 1'b0};
      tab4[7] = '{32'h1F1E1D1C, 16'h3C00, 8'h22, 1'b1};
      tab4[8] = '{32'h23222120, 16'h4000, 8'h33, 1'b0};

      for (int b = 0; b < 36; b++) beat[b*8 +: 8] = 8'(b);
      for (int m = 0; m < 16; m++) begin
         meta_sc[m] = 16'h3800 + 16'(m);
         meta_zr[m] = 8'h40 + 8'(m);
      end

      rst_i = 1'b1; clear_i = 1'b0; group_size_i = '0;
      meta_valid_i = 1'b0; meta_scales_i = '0; meta_zeros_i = '0;
      qw_valid_i = 1'b0; qw_data_i = '0; int4_mode_i = 1'b0; out_ready_i = 1'b1;
      repeat (3) step();
      chk("rst_out_valid",  64'(out_valid_o),  64'd0);
      chk("rst_meta_ready", 64'(meta_ready_o), 64'd0);
      chk("rst_qw_ready",   64'(qw_ready_o),   64'd0);
      chk("rst_qw",         64'(qw_o),         64'd0);
      chk("rst_scales",     scales_o,          64'd0);
      chk("rst_glast",      64'(group_last_o), 64'd0);
      rst_i = 1'b0;

      // One group spanning the whole beat.
      meta_sc[0] = 16'h3800; meta_zr[0] = 8'h11;
      for (int v = 0; v < 9; v++) exp_v[v] = '{tab4[v].qw, 16'h3800, 8'h11, (v == 8)};
      run(9, 1, 9, 4'b1111, 1'b0);
      check_vecs("g9", 9);
      chk("g9_latency",   64'(lat),          64'd2);
      chk("g9_idle_mrdy", 64'(meta_ready_o), 64'd1);
      chk("g9_idle_qrdy", 64'(qw_ready_o),   64'd0);
      chk("g9_idle_vld",  64'(out_valid_o),  64'd0);
      do_clear();

      // Group size 4: metadata reloads after vectors 4 and 8.
      meta_sc[0] = 16'h3800; meta_zr[0] = 8'h11;
      meta_sc[1] = 16'h3C00; meta_zr[1] = 8'h22;
      meta_sc[2] = 16'h4000; meta_zr[2] = 8'h33;
      for (int v = 0; v < 9; v++) exp_v[v] = tab4[v];
      run(4, 3, 9, 4'b1111, 1'b0);
      check_vecs("g4", 9);
      chk("g4_metas",     64'(metas_used),   64'd3);
      chk("g4_fetch_qrdy", 64'(qw_ready_o),  64'd1);
      chk("g4_fetch_mrdy", 64'(meta_ready_o), 64'd0);
      do_clear();

      // Output stalls with out_ready 1,0,0,1 repeating.
      meta_sc[0] = 16'h3800; meta_zr[0] = 8'h11;
      for (int v = 0; v < 9; v++) exp_v[v] = '{tab4[v].qw, 16'h3800, 8'h11, (v == 8)};
      run(9, 1, 9, 4'b1001, 1'b0);
      check_vecs("stall", 9);
      chk("stall_metas", 64'(metas_used), 64'd1);
      do_clear();

      // group_size 0 behaves as 1: every vector closes a group.
      for (int m = 0; m < 9; m++) begin
         meta_sc[m] = 16'h3800 + 16'(m);
         meta_zr[m] = 8'h40 + 8'(m);
      end
      for (int v = 0; v < 9; v++) exp_v[v] = '{tab4[v].qw, 16'h3800 + 16'(v), 8'h40 + 8'(v), 1'b1};
      run(0, 9, 9, 4'b1111, 1'b0);
      check_vecs("g0", 9);
      chk("g0_metas",     64'(metas_used),   64'd9);
      chk("g0_idle_mrdy", 64'(meta_ready_o), 64'd1);
      do_clear();

      // Reset while slice 4 sits in the output register.
      begin
         int  n;
         logic seen;
         seen = 1'b0;
         group_size_i  = GW'(9);
         meta_valid_i  = 1'b1;
         meta_scales_i = {H{16'h3800}};
         meta_zeros_i  = {H{8'h11}};
         qw_valid_i    = 1'b1;
         qw_data_i     = beat;
         out_ready_i   = 1'b1;
         for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (out_valid_o && qw_o == 32'h13121110) seen = 1'b1;
         end
         chk("rst_mid_reached_slice4", 64'(seen), 64'd1);
         rst_i = 1'b1;
         @(posedge clk);
         @(negedge clk);
         chk("rst_mid_vld",    64'(out_valid_o),  64'd0);
         chk("rst_mid_qw",     64'(qw_o),         64'd0);
         chk("rst_mid_scales", scales_o,          64'd0);
         chk("rst_mid_zeros",  64'(zeros_o),      64'd0);
         chk("rst_mid_glast",  64'(group_last_o), 64'd0);
         chk("rst_mid_mrdy",   64'(meta_ready_o), 64'd0);
         chk("rst_mid_qrdy",   64'(qw_ready_o),   64'd0);
         rst_i        = 1'b0;
         meta_valid_i = 1'b0;
         qw_valid_i   = 1'b0;
         @(posedge clk);
         @(negedge clk);
         chk("rst_rel_mrdy", 64'(meta_ready_o), 64'd1);
         n = 0;
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid_o) n++;
         end
         chk("rst_no_stale_out", 64'(n), 64'd0);
         step();
      end
      do_clear();

`ifdef REDMULE_QW_INT4_EN
      // Packed nibbles: byte0=0xA5 gives lane0=0x05, lane1=0x0A; 18 vectors per beat.
      beat[7:0]  = 8'hA5;
      meta_sc[0] = 16'h3800; meta_zr[0] = 8'h11;
      run(18, 1, 18, 4'b1111, 1'b1);
      if (got_qw.size() == 18) begin
         chk("int4_v0_qw",    64'(got_qw[0]),  64'h00010A05);
         chk("int4_v1_qw",    64'(got_qw[1]),  64'h00030002);
         chk("int4_v17_qw",   64'(got_qw[17]), 64'h02030202);
         chk("int4_v16_glast", 64'(got_gl[16]), 64'd0);
         chk("int4_v17_glast", 64'(got_gl[17]), 64'd1);
         chk("int4_zero",     64'(got_zr[0]),  64'h11111111);
      end
      int4_mode_i = 1'b0;
      do_clear();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
